core_done_arbiter: RTL and testbench
====================================

# core_done_arbiter

Collects per-core completion events and serializes them into the single-ID enqueue pulse stream consumed by `core_simple_queue`. Each rising edge on a core's `core_done` line is latched as a pending bit. Pending bits are granted one at a time and emitted as a registered `enqueue_id` / `enqueue_valid` pulse. Pulses are always separated by low gaps so the downstream edge-detecting enqueue never merges two events.

## Interface
- `CORES`, 4, number of cores; must be ≥ 2.
- `PULSE_LEN`, 1, cycles `enqueue_valid` is held high per grant; must be ≥ 1.
- `GAP_LEN`, 1, minimum cycles `enqueue_valid` is held low after each pulse; must be ≥ 1.
- Reset is synchronous, active-high, on `reset`. Single clock `clk`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `core_done`  in  CORES  per-core done level; a 0→1 transition is one event.
- `enqueue_id`  out  $clog2(CORES)  granted core index.
- `enqueue_valid`  out  1  grant pulse; connects to the queue's `enqueue_valid`.
- `pending`  out  CORES  latched, not-yet-granted events.
- `busy`  out  1  high when the FSM is not IDLE or `pending` ≠ 0.
- `dup_error`  out  1  sticky; set when an event arrives for a core whose pending bit is already set.

## Operation
- Edge detect: register `done_d <= core_done`. `rise = core_done & ~done_d`.
- Pending update each cycle: `pending <= (pending & ~grant_clr) | rise`.
  - If a set and a clear hit the same bit in the same cycle, the set wins: the new event is kept.
- Duplicate event: if `rise[i]` and `pending[i]` (and bit i is not being cleared this cycle), set `dup_error` and keep one pending bit. Only one event is recorded.
- FSM states: IDLE, PULSE, GAP. Counter `cnt` is wide enough for max(PULSE_LEN, GAP_LEN).
  - IDLE: if `pending` ≠ 0, pick a winner `w`, then:
    - `enqueue_id <= w`
    - `enqueue_valid <= 1`
    - clear `pending[w]`
    - `cnt <= PULSE_LEN-1`
    - go to PULSE.
  - PULSE: if `cnt` = 0, then `enqueue_valid <= 0`, `cnt <= GAP_LEN-1`, go to GAP. Otherwise decrement `cnt`.
  - GAP: if `cnt` = 0, go to IDLE. Otherwise decrement `cnt`.
- `enqueue_id` stays stable from the grant until the next grant.
- Events on `rise` in the current cycle are not visible to the picker until the next cycle, because the picker reads registered `pending`.
- Winner selection uses round-robin (see Configuration).
- Reset mid-pulse: FSM goes to IDLE and `enqueue_valid` goes to 0 in the next cycle. Pending events are discarded.

## Timing
- Reset values:
  - `enqueue_valid` = 0, `enqueue_id` = 0, `pending` = 0, `dup_error` = 0, `busy` = 0.
  - FSM = IDLE, `last_grant` = CORES-1.
  - `done_d` = all ones, so a `core_done` already high at reset release is not an event.
- Latency:
  - Edge of `core_done` at cycle t: `pending` is set at t+1, and `enqueue_valid` rises at t+2 if the FSM is IDLE.
- Throughput: one grant per PULSE_LEN + GAP_LEN + 1 cycles. With defaults this is one grant every 3 cycles.
- Between pulses `enqueue_valid` is always low for at least GAP_LEN+1 ≥ 2 cycles.

## Configuration
- `CORE_DONE_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at `last_grant+1`, modulo CORES.
  - `last_grant` updates to `w` on each grant.
- Not defined: fixed priority. The lowest-index pending core wins, and `last_grant` is unused.

## Structure
- Package `core_done_arb_pkg`:
  - `arb_state_t` enum (IDLE, PULSE, GAP)
  - function `core_idx_w(CORES)`
- Sub-module `core_rr_picker`: combinational.
  - Inputs: `req[CORES]`, `base` index.
  - Outputs: `grant_idx`, `grant_any`.
  - Fixed priority is the picker with `base` tied to 0.

## Test plan
- Single event: `core_done[2]` rises at cycle 10 → `pending[2]` at 11; `enqueue_valid`=1 with `enqueue_id`=2 at 12 only; low at 13.
- Simultaneous events, RR on: `core_done` = 4'b1011 rise together after reset → IDs 0, 1, 3 in order, pulses 3 cycles apart, each followed by ≥ 2 low cycles.
- RR fairness: core 0 re-fires immediately after each grant while core 3 is pending → grants alternate 0, 3, 0. Without the macro → 0, 0, 0 until core 0 stops.
- Duplicate event: pulse `core_done[1]` twice (0→1→0→1) before its grant → exactly one ID-1 pulse, and `dup_error`=1 stays high until reset.
- Set/clear collision: `core_done[0]` rises in the same cycle core 0 is granted → a second ID-0 pulse follows after the gap; `dup_error` stays 0.
- Reset mid-PULSE with PULSE_LEN=3: assert `reset` during the second cycle of valid → `enqueue_valid`=0 and `pending`=0 the next cycle. A `core_done` held high through reset produces no event.

Source files
------------

// File: rtl/core_done_arb_pkg.sv
// Shared types and width helpers for the core completion arbiter.
package core_done_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Width of a core index; never narrower than one bit.
    function automatic int core_idx_w(input int cores);
        return (cores <= 2) ? 1 : $clog2(cores);
    endfunction

    // Width of a down-counter that starts at max(pulse_len, gap_len) - 1.
    function automatic int cnt_w(input int pulse_len, input int gap_len);
        int m;
        m = (pulse_len > gap_len) ? pulse_len : gap_len;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/core_done_arbiter_if.sv
// Bundle between the per-core done lines, the arbiter and the enqueue consumer.
interface core_done_arbiter_if #(
    parameter int CORES = 4
);
    import core_done_arb_pkg::*;

    localparam int ID_W = core_idx_w(CORES);

    // enqueue_valid is a level pulse, not a valid/ready handshake: the consumer
    // edge-detects it, so every high run is one event and low gaps separate events.
    logic [CORES-1:0] core_done;
    logic [ID_W-1:0]  enqueue_id;
    logic             enqueue_valid;
    logic [CORES-1:0] pending;
    logic             busy;
    logic             dup_error;
    arb_state_t       fsm_state;

    modport master (
        input  core_done,
        output enqueue_id, enqueue_valid, pending, busy, dup_error, fsm_state
    );

    modport slave (
        output core_done,
        input  enqueue_id, enqueue_valid, pending, busy, dup_error, fsm_state
    );

endinterface

// File: rtl/core_rr_picker.sv
// Combinational rotating-priority picker: first set req at or after base wins.
module core_rr_picker
    import core_done_arb_pkg::*;
#(
    parameter int CORES = 4,
    parameter int ID_W  = core_idx_w(CORES)
) (
    input  logic [CORES-1:0] req,
    input  logic [ID_W-1:0]  base,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);

    logic [ID_W:0] idx;

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < CORES; k++) begin
            idx = {1'b0, base} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(CORES)) idx = idx - (ID_W + 1)'(CORES);
            if (!grant_any && req[idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/core_done_arbiter.sv
// Serializes per-core done edges into gapped single-ID enqueue pulses.
// Define CORE_DONE_ARB_RR_EN for round-robin; default is lowest-index-first.
module core_done_arbiter
    import core_done_arb_pkg::*;
#(
    parameter int CORES     = 4,
    parameter int PULSE_LEN = 1,
    parameter int GAP_LEN   = 1
) (
    input  logic clk,
    input  logic reset,
    core_done_arbiter_if.master bus
);

    localparam int ID_W  = core_idx_w(CORES);
    localparam int CNT_W = cnt_w(PULSE_LEN, GAP_LEN);

    logic [CORES-1:0] done_d;
    logic [CORES-1:0] pending_q;
    logic [CORES-1:0] rise;
    logic [CORES-1:0] grant_clr;
    logic [ID_W-1:0]  base;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;
    logic [ID_W-1:0]  enqueue_id_q;
    logic             enqueue_valid_q;
    logic             dup_q;
    logic [CNT_W-1:0] cnt;
    arb_state_t       state;

    assign rise = bus.core_done & ~done_d;

`ifdef CORE_DONE_ARB_RR_EN
    logic [ID_W-1:0] last_grant;
    assign base = (last_grant == ID_W'(CORES - 1)) ? '0 : last_grant + 1'b1;
`else
    assign base = '0;
`endif

    core_rr_picker #(.CORES(CORES), .ID_W(ID_W)) u_picker (
        .req       (pending_q),
        .base      (base),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        grant_clr = '0;
        if (state == IDLE && grant_any) grant_clr[grant_idx] = 1'b1;
    end

    // A rise on a bit being cleared this cycle re-arms it and is not a duplicate.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_d          <= '1;
            pending_q       <= '0;
            dup_q           <= 1'b0;
            state           <= IDLE;
            enqueue_valid_q <= 1'b0;
            enqueue_id_q    <= '0;
            cnt             <= '0;
`ifdef CORE_DONE_ARB_RR_EN
            last_grant      <= ID_W'(CORES - 1);
`endif
        end else begin
            done_d    <= bus.core_done;
            pending_q <= (pending_q & ~grant_clr) | rise;
            if (|(rise & pending_q & ~grant_clr)) dup_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        enqueue_id_q    <= grant_idx;
                        enqueue_valid_q <= 1'b1;
                        cnt             <= CNT_W'(PULSE_LEN - 1);
                        state           <= PULSE;
`ifdef CORE_DONE_ARB_RR_EN
                        last_grant      <= grant_idx;
`endif
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        enqueue_valid_q <= 1'b0;
                        cnt             <= CNT_W'(GAP_LEN - 1);
                        state           <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.enqueue_id    = enqueue_id_q;
    assign bus.enqueue_valid = enqueue_valid_q;
    assign bus.pending       = pending_q;
    assign bus.dup_error     = dup_q;
    assign bus.busy          = (state != IDLE) || (|pending_q);
    assign bus.fsm_state     = state;

endmodule

// File: tb/tb_core_done_arbiter.sv
// Directed bench for core_done_arbiter: vector table plus fairness and reset sequences.
module tb_core_done_arbiter;
  import core_done_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  always #5 clk = ~clk;

  core_done_arbiter_if #(.CORES(4)) bus1 ();
  core_done_arbiter_if #(.CORES(4)) bus2 ();

  core_done_arbiter #(.CORES(4), .PULSE_LEN(1), .GAP_LEN(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  core_done_arbiter #(.CORES(4), .PULSE_LEN(3), .GAP_LEN(1)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  typedef struct {
    logic       rst;
    logic [3:0] cd;
    logic       ev;
    logic [1:0] eid;
    logic [3:0] ep;
    logic       edup;
    logic       ebusy;
  } vec_t;

  vec_t vecs[$];
  logic [1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic [3:0] cd, input logic ev, input logic [1:0] eid,
                     input logic [3:0] ep, input logic edup, input logic ebusy);
    vec_t v;
    v.rst = rst; v.cd = cd; v.ev = ev; v.eid = eid; v.ep = ep; v.edup = edup; v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cd;
    logic       prev_v;
    int         grants;
    int         high_cycles;

    reset = 1'b1;
    reset2 = 1'b1;
    bus1.core_done = '0;
    bus2.core_done = '0;
    tick();
    tick();

    // single event on core 2
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0100, 0, 0, 4'b0100, 0, 1);
    add(0, 4'b0100, 1, 2, 4'b0000, 0, 1);
    add(0, 4'b0000, 0, 2, 4'b0000, 0, 1);
    add(0, 4'b0000, 0, 2, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 2, 4'b0000, 0, 0);
    // simultaneous 1011 after reset
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b1011, 0, 0, 4'b1011, 0, 1);
    add(0, 4'b1011, 1, 0, 4'b1010, 0, 1);
    add(0, 4'b1011, 0, 0, 4'b1010, 0, 1);
    add(0, 4'b1011, 0, 0, 4'b1010, 0, 1);
    add(0, 4'b1011, 1, 1, 4'b1000, 0, 1);
    add(0, 4'b0000, 0, 1, 4'b1000, 0, 1);
    add(0, 4'b0000, 0, 1, 4'b1000, 0, 1);
    add(0, 4'b0000, 1, 3, 4'b0000, 0, 1);
    add(0, 4'b0000, 0, 3, 4'b0000, 0, 1);
    add(0, 4'b0000, 0, 3, 4'b0000, 0, 0);
    // duplicate event on core 1 while core 0 is being granted
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0011, 0, 0, 4'b0011, 0, 1);
    add(0, 4'b0000, 1, 0, 4'b0010, 0, 1);
    add(0, 4'b0010, 0, 0, 4'b0010, 1, 1);
    add(0, 4'b0000, 0, 0, 4'b0010, 1, 1);
    add(0, 4'b0000, 1, 1, 4'b0000, 1, 1);
    add(0, 4'b0000, 0, 1, 4'b0000, 1, 1);
    add(0, 4'b0000, 0, 1, 4'b0000, 1, 0);
    add(0, 4'b0000, 0, 1, 4'b0000, 1, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // set/clear collision on core 0
    add(0, 4'b0100, 0, 0, 4'b0100, 0, 1);
    add(0, 4'b0001, 1, 2, 4'b0001, 0, 1);
    add(0, 4'b0000, 0, 2, 4'b0001, 0, 1);
    add(0, 4'b0000, 0, 2, 4'b0001, 0, 1);
    add(0, 4'b0001, 1, 0, 4'b0001, 0, 1);
    add(0, 4'b0000, 0, 0, 4'b0001, 0, 1);
    add(0, 4'b0000, 0, 0, 4'b0001, 0, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      bus1.core_done = vecs[i].cd;
      tick();
      check($sformatf("v%0d_valid", i), 8'(bus1.enqueue_valid), 8'(vecs[i].ev));
      check($sformatf("v%0d_id", i), 8'(bus1.enqueue_id), 8'(vecs[i].eid));
      check($sformatf("v%0d_pending", i), 8'(bus1.pending), 8'(vecs[i].ep));
      check($sformatf("v%0d_dup", i), 8'(bus1.dup_error), 8'(vecs[i].edup));
      check($sformatf("v%0d_busy", i), 8'(bus1.busy), 8'(vecs[i].ebusy));
    end

    // fairness: core 0 re-fires right after each of its grants while core 3 waits
    reset = 1'b1;
    bus1.core_done = '0;
    tick();
    reset = 1'b0;
    tick();
`ifdef CORE_DONE_ARB_RR_EN
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
`else
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
`endif
    cd = 4'b1001;
    prev_v = 1'b0;
    grants = 0;
    for (int c = 0; c < 40 && grants < 3; c++) begin
      bus1.core_done = cd;
      tick();
      if (bus1.enqueue_valid && !prev_v) begin
        check($sformatf("fair_grant%0d", grants), 8'(bus1.enqueue_id), 8'(exp_q.pop_front()));
        grants++;
        cd = 4'b1001;
      end else begin
        cd = 4'b1000;
      end
      prev_v = bus1.enqueue_valid;
    end
    check("fair_grant_count", 8'(grants), 8'd3);
    check("fair_queue_empty", 8'(exp_q.size()), 8'd0);

    // reset in the second cycle of a 3-cycle pulse; core_done held through reset
    reset2 = 1'b1;
    bus2.core_done = '0;
    tick();
    reset2 = 1'b0;
    tick();
    bus2.core_done = 4'b0001;
    tick();
    check("r2_pending_set", 8'(bus2.pending), 8'b0001);
    tick();
    check("r2_valid_c1", 8'(bus2.enqueue_valid), 8'd1);
    check("r2_id_c1", 8'(bus2.enqueue_id), 8'd0);
    tick();
    check("r2_valid_c2", 8'(bus2.enqueue_valid), 8'd1);
    reset2 = 1'b1;
    bus2.core_done = 4'b0011;
    tick();
    check("r2_valid_after_reset", 8'(bus2.enqueue_valid), 8'd0);
    check("r2_pending_after_reset", 8'(bus2.pending), 8'd0);
    check("r2_state_after_reset", 8'(bus2.fsm_state), 8'(IDLE));
    check("r2_busy_after_reset", 8'(bus2.busy), 8'd0);
    reset2 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("r2_held_pending%0d", c), 8'(bus2.pending), 8'd0);
      check($sformatf("r2_held_valid%0d", c), 8'(bus2.enqueue_valid), 8'd0);
    end

    // clean 3-cycle pulse length on core 2
    bus2.core_done = 4'b0000;
    tick();
    bus2.core_done = 4'b0100;
    tick();
    high_cycles = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus2.enqueue_valid) begin
        high_cycles++;
        check($sformatf("r2_pulse_id%0d", c), 8'(bus2.enqueue_id), 8'd2);
      end
    end
    check("r2_pulse_len", 8'(high_cycles), 8'd3);
    check("r2_dup", 8'(bus2.dup_error), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
